// File: rtl/simon_sequencer_if.sv
// Random-value handshake between the colour producer and the sequencer.
// Signals: rnd_ready/rnd_value (producer -> sequencer), rnd_take (back).
interface simon_sequencer_if;
    logic       rnd_ready;
    logic [1:0] rnd_value;
    logic       rnd_take;

    modport master (
        output rnd_ready,
        output rnd_value,
        input  rnd_take
    );

    modport slave (
        input  rnd_ready,
        input  rnd_value,
        output rnd_take
    );
endinterface

// File: rtl/simon_sequencer.sv
// Simon game controller: grows a colour sequence, replays it, checks presses.
// Ports: clk, rst (sync, active-high), start, rnd (slave handshake),
//        btn_valid/btn_code in; led_on/led_code, level, busy, win, lose out.
module simon_sequencer #(
    parameter int MAX_LEN        = 16,
    parameter int SHOW_CYCLES    = 50_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000,
    localparam int LW            = $clog2(MAX_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    simon_sequencer_if.slave    rnd,
    input  logic                btn_valid,
    input  logic [1:0]          btn_code,
    output logic                led_on,
    output logic [1:0]          led_code,
    output logic [LW-1:0]       level,
    output logic                busy,
    output logic                win,
    output logic                lose
);

    localparam int AW = $clog2(MAX_LEN);

    // One shared down-counter, sized for the longest interval.
    localparam int TMAX_SG = (SHOW_CYCLES > GAP_CYCLES) ?
                             SHOW_CYCLES : GAP_CYCLES;
    localparam int TMAX    = (TMAX_SG > TIMEOUT_CYCLES) ?
                             TMAX_SG : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0] SHOW_LD = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TOUT_LD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHOW_ON,
        SHOW_OFF,
        WAIT_IN,
        WIN,
        LOSE
    } state_t;

    state_t        state;
    logic [LW-1:0] len;
    logic [LW-1:0] idx;
    logic [TW-1:0] tmr;
    logic [1:0]    mem [MAX_LEN];

    logic last;
    logic tmr_zero;

    assign last     = (idx == len - LW'(1));
    assign tmr_zero = (tmr == '0);

    // mem is deliberately left out of reset; only entries below len are read.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            len   <= '0;
            idx   <= '0;
            tmr   <= '0;
        end else begin
            unique case (state)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        len   <= '0;
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (rnd.rnd_ready) begin
                        mem[len[AW-1:0]] <= rnd.rnd_value;
                        len   <= len + LW'(1);
                        idx   <= '0;
                        tmr   <= SHOW_LD;
                        state <= SHOW_ON;
                    end
                end
                SHOW_ON: begin
                    if (tmr_zero) begin
                        tmr   <= GAP_LD;
                        state <= SHOW_OFF;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                SHOW_OFF: begin
                    if (!tmr_zero) begin
                        tmr <= tmr - TW'(1);
                    end else if (last) begin
                        idx   <= '0;
                        tmr   <= TOUT_LD;
                        state <= WAIT_IN;
                    end else begin
                        idx   <= idx + LW'(1);
                        tmr   <= SHOW_LD;
                        state <= SHOW_ON;
                    end
                end
                WAIT_IN: begin
                    // A press in the tmr=0 cycle takes priority over timeout.
                    if (btn_valid) begin
                        if (btn_code != mem[idx[AW-1:0]]) begin
                            state <= LOSE;
                        end else if (!last) begin
                            idx <= idx + LW'(1);
                            tmr <= TOUT_LD;
                        end else if (len == LEN_MAX) begin
                            state <= WIN;
                        end else begin
                            state <= FETCH;
                        end
                    end else if (tmr_zero) begin
                        state <= LOSE;
                    end else begin
                        tmr <= tmr - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rnd.rnd_take = (state == FETCH) && rnd.rnd_ready;
    assign led_on       = (state == SHOW_ON);
    assign led_code     = led_on ? mem[idx[AW-1:0]] : 2'd0;
    assign level        = len;
    assign busy         = (state == FETCH)    || (state == SHOW_ON) ||
                          (state == SHOW_OFF) || (state == WAIT_IN);
    assign win          = (state == WIN);
    assign lose         = (state == LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: directed game scenarios plus random games.
// Expected outputs come from a queue-based model of the game rules.
module tb_simon_sequencer;

    localparam int ML = 4;
    localparam int SC = 3;
    localparam int GC = 2;
    localparam int TC = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       btn_valid;
    logic [1:0] btn_code;
    logic       led_on;
    logic [1:0] led_code;
    logic [2:0] level;
    logic       busy;
    logic       win;
    logic       lose;

    simon_sequencer_if rif ();

    simon_sequencer #(
        .MAX_LEN        (ML),
        .SHOW_CYCLES    (SC),
        .GAP_CYCLES     (GC),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rnd       (rif),
        .btn_valid (btn_valid),
        .btn_code  (btn_code),
        .led_on    (led_on),
        .led_code  (led_code),
        .level     (level),
        .busy      (busy),
        .win       (win),
        .lose      (lose)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         res;
    logic [1:0] seq [$];
    logic [1:0] vals [4] = '{2'd1, 2'd3, 2'd0, 2'd2};

    // {rnd_take, led_on, led_code, level, busy, win, lose}
    logic [9:0] obs;
    assign obs = {rif.rnd_take, led_on, led_code, level, busy, win, lose};

    function automatic logic [9:0] pk(input logic t, input logic on,
                                      input logic [1:0] c, input int lv,
                                      input logic b, input logic w,
                                      input logic l);
        return {t, on, c, 3'(lv), b, w, l};
    endfunction

    task automatic chk(input string tag, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_game();
        seq.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start", pk(0, 0, 0, 0, 1, 0, 0));
    endtask

    task automatic fetch(input logic [1:0] v, input int hold,
                         input logic stray);
        int n = seq.size();
        for (int i = 0; i < hold; i++) begin
            rif.rnd_ready = 1'b0;
            if (stray) begin
                btn_valid = 1'($urandom_range(0, 1));
                btn_code  = 2'($urandom_range(0, 3));
            end
            chk("fetch_hold", pk(0, 0, 0, n, 1, 0, 0));
            tick();
        end
        btn_valid     = 1'b0;
        rif.rnd_ready = 1'b1;
        rif.rnd_value = v;
        #1;
        chk("fetch_take", pk(1, 0, 0, n, 1, 0, 0));
        tick();
        rif.rnd_ready = 1'b0;
        rif.rnd_value = 2'($urandom_range(0, 3));
        seq.push_back(v);
    endtask

    task automatic playback(input logic stray);
        int n = seq.size();
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < SC; c++) begin
                if (stray) begin
                    btn_valid = 1'($urandom_range(0, 1));
                    btn_code  = 2'($urandom_range(0, 3));
                end
                chk($sformatf("show%0d", i), pk(0, 1, seq[i], n, 1, 0, 0));
                tick();
            end
            for (int c = 0; c < GC; c++) begin
                chk($sformatf("gap%0d", i), pk(0, 0, 0, n, 1, 0, 0));
                tick();
            end
        end
        btn_valid = 1'b0;
    endtask

    // res: 0 continue, 1 next round, 2 win, 3 lose
    task automatic press(input logic [1:0] code, input int pos,
                         output int r);
        int   n = seq.size();
        logic bad;
        logic fin;
        logic w;
        btn_valid = 1'b1;
        btn_code  = code;
        tick();
        btn_valid = 1'b0;
        bad = (code != seq[pos]);
        fin = (pos == n - 1);
        w   = !bad && fin && (n == ML);
        chk($sformatf("press%0d", pos),
            pk(0, 0, 0, n, !bad && !w, w, bad));
        r = bad ? 3 : w ? 2 : fin ? 1 : 0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        btn_valid     = 1'b0;
        btn_code      = 2'd0;
        rif.rnd_ready = 1'b0;
        rif.rnd_value = 2'd0;
        repeat (2) tick();
        chk("reset", pk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        tick();
        chk("idle", pk(0, 0, 0, 0, 0, 0, 0));

        // First colour 2 with ready already high, then time out
        start         = 1'b1;
        rif.rnd_ready = 1'b1;
        rif.rnd_value = 2'd2;
        chk("idle_ready", pk(0, 0, 0, 0, 0, 0, 0));
        tick();
        start = 1'b0;
        chk("t1_take", pk(1, 0, 0, 0, 1, 0, 0));
        tick();
        seq.delete();
        seq.push_back(2'd2);
        playback(1'b0);
        rif.rnd_ready = 1'b0;
        for (int i = 0; i < TC; i++) begin
            chk("wait", pk(0, 0, 0, 1, 1, 0, 0));
            tick();
        end
        chk("timeout", pk(0, 0, 0, 1, 0, 0, 1));

        // Full winning game 1,3,0,2 with slow ready and stray presses
        start_game();
        for (int r = 0; r < ML; r++) begin
            fetch(vals[r], (r == 1) ? 20 : 0, r == 1);
            playback(r == 2);
            for (int p = 0; p <= r; p++) press(seq[p], p, res);
        end
        tick();
        chk("win_hold", pk(0, 0, 0, 4, 0, 1, 0));

        // Wrong second press at level 2
        start_game();
        fetch(2'd1, 0, 1'b0);
        playback(1'b0);
        press(2'd1, 0, res);
        fetch(2'd3, 0, 1'b0);
        playback(1'b0);
        press(2'd1, 0, res);
        press(2'd2, 1, res);
        tick();
        chk("lose_hold", pk(0, 0, 0, 2, 0, 0, 1));

        // Presses landing exactly in the tmr=0 cycle
        start_game();
        fetch(2'($urandom_range(0, 3)), 0, 1'b0);
        playback(1'b0);
        press(seq[0], 0, res);
        fetch(2'($urandom_range(0, 3)), 0, 1'b0);
        playback(1'b0);
        repeat (TC - 1) tick();
        press(seq[0], 0, res);
        repeat (TC - 1) tick();
        press(seq[1], 1, res);

        // Reset during playback at level 3
        fetch(2'($urandom_range(0, 3)), 0, 1'b0);
        tick();
        chk("show_l3", pk(0, 1, seq[0], 3, 1, 0, 0));
        rst = 1'b1;
        tick();
        chk("rst_mid", pk(0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        start_game();
        fetch(2'($urandom_range(0, 3)), 0, 1'b0);
        playback(1'b0);
        press(~seq[0], 0, res);

        // Random games with occasional wrong presses
        for (int g = 0; g < 3; g++) begin
            bit done = 1'b0;
            start_game();
            while (!done) begin
                fetch(2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'b1);
                playback(1'b1);
                for (int p = 0; p < seq.size() && !done; p++) begin
                    logic [1:0] c = seq[p];
                    if ($urandom_range(0, 7) == 0)
                        c = 2'($urandom_range(0, 3));
                    press(c, p, res);
                    if (res >= 2) done = 1'b1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

Game controller for the Simon (Genius) design. It pulls colour codes from the random-value producer through the control interface's ready/value signals and appends them to an internal sequence memory. It then replays the sequence on the LED outputs and checks the player's button presses against it. The game ends in a win on reaching MAX_LEN, or in a loss on a wrong press or a timeout.

## Interface

Parameters:
- MAX_LEN, 16: sequence length needed to win, 2..32; LW = $clog2(MAX_LEN+1).
- SHOW_CYCLES, 50_000_000: clock cycles each colour is lit during playback, ≥1.
- GAP_CYCLES, 12_500_000: dark cycles after each lit colour, ≥1.
- TIMEOUT_CYCLES, 250_000_000: maximum cycles allowed between presses in WAIT_IN, ≥2.

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
  - clk, input, 1: system clock; all state changes on its rising edge.
  - rst, input, 1: synchronous, active-high reset.
- start, input, 1: level-sampled game start/restart request.
- rnd_ready, input, 1: consumer-side ready from the control interface.
- rnd_value, input, 2: consumer-side colour code (0..3 = colours 1..4).
- rnd_take, output, 1: one-cycle pulse in the cycle rnd_value is captured.
- btn_valid, input, 1: one-cycle pulse per debounced player press.
- btn_code, input, 2: colour of the press, valid with btn_valid.
- led_on, output, 1: playback LED enable.
- led_code, output, 2: colour being shown; 0 when led_on=0.
- level, output, LW: current sequence length.
- busy, output, 1: high in FETCH, SHOW_ON, SHOW_OFF and WAIT_IN.
- win, output, 1: high while in WIN.
- lose, output, 1: high while in LOSE.

## Operation

- Storage: mem[0..MAX_LEN-1] × 2 bits. Registers len (LW bits), idx (LW bits), and one shared down-counter tmr sized for the largest of the three cycle parameters.
- States: IDLE, FETCH, SHOW_ON, SHOW_OFF, WAIT_IN, WIN, LOSE.
- IDLE/WIN/LOSE, start=1: len←0, idx←0, go to FETCH. start is ignored in every other state.
- FETCH: wait for rnd_ready=1. In that cycle:
  - mem[len]←rnd_value, rnd_take=1.
  - len←len+1, idx←0, tmr←SHOW_CYCLES-1.
  - Go to SHOW_ON.
- SHOW_ON: led_on=1, led_code=mem[idx]. When tmr=0: tmr←GAP_CYCLES-1, go to SHOW_OFF. Otherwise tmr decrements.
- SHOW_OFF: led_on=0. When tmr=0:
  - If idx=len-1: idx←0, tmr←TIMEOUT_CYCLES-1, go to WAIT_IN.
  - Else: idx←idx+1, tmr←SHOW_CYCLES-1, go to SHOW_ON.
- WAIT_IN, on btn_valid=1:
  - btn_code≠mem[idx]: go to LOSE.
  - Match and idx<len-1: idx←idx+1, tmr reloads to TIMEOUT_CYCLES-1.
  - Match and idx=len-1 and len=MAX_LEN: go to WIN.
  - Match and idx=len-1 and len<MAX_LEN: go to FETCH.
- WAIT_IN, btn_valid=0: tmr decrements. When tmr=0, go to LOSE.
- If btn_valid=1 in the same cycle tmr=0, the press wins: it is evaluated and the timeout is not taken.
- btn_valid outside WAIT_IN is ignored; it does not affect idx, tmr or mem.
- WIN/LOSE hold their state until start. level keeps the final len so the score stays readable.
- mem is not cleared on reset or restart. Only entries below len are ever read.

## Timing

- Reset values: state=IDLE, len=0, idx=0, tmr=0. All outputs are 0: rnd_take, led_on, led_code, level, busy, win, lose.
- Reset mid-game returns to IDLE in the next cycle, overriding every other condition.
- All outputs are registered or decoded from state/registers only. There is no combinational path from btn_* or start to any output.
- rnd_take is asserted in the same cycle rnd_ready is sampled high. At most one capture happens per FETCH visit.
- FETCH→SHOW_ON takes 1 cycle after rnd_ready. led_on rises in the first SHOW_ON cycle.
- Each colour is lit for exactly SHOW_CYCLES cycles and dark for exactly GAP_CYCLES cycles.
- Full playback of length L takes L·(SHOW_CYCLES+GAP_CYCLES) cycles.
- A press is evaluated in its btn_valid cycle. win/lose/FETCH becomes visible in the next cycle.

## Test plan

Parameters for the bench: MAX_LEN=4, SHOW_CYCLES=3, GAP_CYCLES=2, TIMEOUT_CYCLES=10.

1. Reset, then start with rnd_ready=1 and rnd_value=2 -> rnd_take pulses once; level=1; led_on=1 with led_code=2 for 3 cycles, then 0 for 2 cycles; busy=1 throughout.
2. Random values 1,3,0,2 and correct presses after each playback -> level steps 1→4; win=1 after the 4th correct press of round 4; busy=0.
3. Level 2 with sequence 1,3, player presses 1 then 2 -> lose=1 in the cycle after the 2nd press; level stays 2.
4. In WAIT_IN, no press for 10 cycles -> lose=1. Repeat with a correct btn_valid landing in the tmr=0 cycle -> no loss, idx advances.
5. rnd_ready held low for 20 cycles in FETCH, then high -> no rnd_take and led_on stays 0 until the ready cycle; stray btn_valid pulses during FETCH and playback are ignored.
6. rst asserted during SHOW_ON at level 3 -> next cycle all outputs 0, state IDLE; a following start begins a fresh game at level 1.
